// File: rtl/irq_collect_8.sv
// Eight-channel interrupt collector: edge/level capture into pending bits, masked grant into an
// output register with valid/ready handshake. Define ROUND_ROBIN_EN for round-robin selection.
module irq_collect_8 #(
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       ovf_clr,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic [7:0] pending,
    output logic       overflow
);

    logic [7:0] req_q;
    logic [7:0] pend_q, pend_d;
    logic       valid_q, valid_d;
    logic [2:0] idx_q, idx_d;
    logic       ovf_q, ovf_d;

    logic [7:0] cap;
    logic [7:0] cand;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       can_load;
    logic       load;

`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] rr_idx;
    logic       found;

    // Search starts one below the last granted channel and wraps modulo 8.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            rr_idx = ptr_q - 3'(k + 1);
            if (!found && cand[rr_idx]) begin
                sel   = rr_idx;
                found = 1'b1;
            end
        end
    end

    assign ptr_d = load ? sel : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (cand[i]) sel = 3'(i);
        end
    end
`endif

    always_comb begin
        cap      = (EDGE_MODE != 0) ? (req_in & ~req_q) : req_in;
        cand     = pend_q & ~mask;
        can_load = !valid_q || out_ready;
        load     = can_load && (cand != '0);
        grant    = load ? (8'b1 << sel) : '0;
        // A fresh capture on the channel being granted keeps it pending and is not an overflow.
        pend_d   = (pend_q & ~grant) | cap;
        ovf_d    = (|(cap & pend_q & ~grant)) | (ovf_q & ~ovf_clr);
        valid_d  = can_load ? (cand != '0) : valid_q;
        idx_d    = load ? sel : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            req_q   <= req_in;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_irq_collect_8.sv
// Directed self-checking bench for irq_collect_8: edge-mode instance for handshake/mask/overflow/reset,
// level-mode instance for the grant-rotation sequence.
module tb_irq_collect_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in, mask;
    logic       ovf_clr, out_ready;
    logic       out_valid, overflow;
    logic [2:0] out_idx;
    logic [7:0] pending;

    logic [7:0] l_req;
    logic       l_ready;
    logic       l_valid, l_ovf;
    logic [2:0] l_idx;
    logic [7:0] l_pend;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_collect_8 #(.EDGE_MODE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ovf_clr(ovf_clr),
        .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
        .pending(pending), .overflow(overflow)
    );

    irq_collect_8 #(.EDGE_MODE(0)) u_lvl (
        .clk(clk), .rst_n(rst_n), .req_in(l_req), .mask(8'h00), .ovf_clr(1'b0),
        .out_ready(l_ready), .out_valid(l_valid), .out_idx(l_idx),
        .pending(l_pend), .overflow(l_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = '0; mask = '0; ovf_clr = 1'b0; out_ready = 1'b1;
        l_req = '0; l_ready = 1'b1;
        #2;
        n_cmp++; if ({out_valid, out_idx, pending, overflow} !== 13'h0) begin
            n_err++; $display("FAIL reset_outputs got %h exp 0", {out_valid, out_idx, pending, overflow});
        end
        n_cmp++; if ({l_valid, l_idx, l_pend, l_ovf} !== 13'h0) begin
            n_err++; $display("FAIL reset_lvl_outputs got %h exp 0", {l_valid, l_idx, l_pend, l_ovf});
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        req_in = 8'h21;
        step();
        n_cmp++; if (pending !== 8'h21 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_c1 got pend=%h v=%b exp pend=21 v=0", pending, out_valid);
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd5 || pending !== 8'h01) begin
            n_err++; $display("FAIL basic_c2 got v=%b idx=%0d pend=%h exp v=1 idx=5 pend=01", out_valid, out_idx, pending);
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h00) begin
            n_err++; $display("FAIL basic_c3 got v=%b idx=%0d pend=%h exp v=1 idx=0 pend=00", out_valid, out_idx, pending);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0 || pending !== 8'h00) begin
            n_err++; $display("FAIL basic_c4 got v=%b pend=%h exp v=0 pend=00", out_valid, pending);
        end
        req_in = 8'h00;
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        req_in = 8'h04; step();
        req_in = 8'h00; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
            n_err++; $display("FAIL stall_grant2 got v=%b idx=%0d exp v=1 idx=2", out_valid, out_idx);
        end
        req_in = 8'h40; step();
        req_in = 8'h00; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd2 || pending !== 8'h40) begin
            n_err++; $display("FAIL stall_hold got v=%b idx=%0d pend=%h exp v=1 idx=2 pend=40", out_valid, out_idx, pending);
        end
        out_ready = 1'b1; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd6 || pending !== 8'h00) begin
            n_err++; $display("FAIL stall_next6 got v=%b idx=%0d pend=%h exp v=1 idx=6 pend=00", out_valid, out_idx, pending);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_drain got v=%b exp v=0", out_valid);
        end
    endtask

    task automatic test_mask();
        mask = 8'h80; req_in = 8'h82; step();
        req_in = 8'h00; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd1 || pending !== 8'h80) begin
            n_err++; $display("FAIL mask_grant1 got v=%b idx=%0d pend=%h exp v=1 idx=1 pend=80", out_valid, out_idx, pending);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0 || pending !== 8'h80) begin
            n_err++; $display("FAIL mask_blocked got v=%b pend=%h exp v=0 pend=80", out_valid, pending);
        end
        mask = 8'h00; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd7 || pending !== 8'h00) begin
            n_err++; $display("FAIL mask_grant7 got v=%b idx=%0d pend=%h exp v=1 idx=7 pend=00", out_valid, out_idx, pending);
        end
        // Masking after load must not revoke the held grant
        out_ready = 1'b0; step();
        req_in = 8'h10; step();
        req_in = 8'h00; mask = 8'hFF; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd7 || pending !== 8'h10) begin
            n_err++; $display("FAIL mask_no_revoke got v=%b idx=%0d pend=%h exp v=1 idx=7 pend=10", out_valid, out_idx, pending);
        end
        out_ready = 1'b1; step();
        n_cmp++; if (out_valid !== 1'b0 || pending !== 8'h10) begin
            n_err++; $display("FAIL mask_all got v=%b pend=%h exp v=0 pend=10", out_valid, pending);
        end
        mask = 8'h00; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd4) begin
            n_err++; $display("FAIL mask_grant4 got v=%b idx=%0d exp v=1 idx=4", out_valid, out_idx);
        end
        step();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        req_in = 8'h01; step();
        req_in = 8'h00; step();
        req_in = 8'h08; step();
        req_in = 8'h00; step();
        n_cmp++; if (overflow !== 1'b0 || pending !== 8'h08 || out_idx !== 3'd0) begin
            n_err++; $display("FAIL ovf_pre got ovf=%b pend=%h idx=%0d exp ovf=0 pend=08 idx=0", overflow, pending, out_idx);
        end
        req_in = 8'h08; step();
        n_cmp++; if (overflow !== 1'b1 || pending !== 8'h08) begin
            n_err++; $display("FAIL ovf_set got ovf=%b pend=%h exp ovf=1 pend=08", overflow, pending);
        end
        req_in = 8'h00; step();
        n_cmp++; if (overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_sticky got ovf=%b exp 1", overflow);
        end
        // Clear and a new overflow in the same cycle: set wins
        req_in = 8'h08; ovf_clr = 1'b1; step();
        n_cmp++; if (overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_set_wins got ovf=%b exp 1", overflow);
        end
        req_in = 8'h00; step();
        n_cmp++; if (overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr got ovf=%b exp 0", overflow);
        end
        ovf_clr = 1'b0;
        req_in = 8'h08; out_ready = 1'b1; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'h08 || overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_recapture got v=%b idx=%0d pend=%h ovf=%b exp v=1 idx=3 pend=08 ovf=0",
                              out_valid, out_idx, pending, overflow);
        end
        req_in = 8'h00; step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'h00) begin
            n_err++; $display("FAIL ovf_regrant got v=%b idx=%0d pend=%h exp v=1 idx=3 pend=00", out_valid, out_idx, pending);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_in = 8'h01; step();
        req_in = 8'h00; step();
        req_in = 8'hFF; step();
        n_cmp++; if (out_valid !== 1'b1 || pending !== 8'hFF) begin
            n_err++; $display("FAIL rmid_pre got v=%b pend=%h exp v=1 pend=FF", out_valid, pending);
        end
        rst_n = 1'b0; req_in = 8'h80;
        #1;
        n_cmp++; if ({out_valid, out_idx, pending, overflow} !== 13'h0) begin
            n_err++; $display("FAIL rmid_async got %h exp 0", {out_valid, out_idx, pending, overflow});
        end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        n_cmp++; if (pending !== 8'h80 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rmid_release_edge got pend=%h v=%b exp pend=80 v=0", pending, out_valid);
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd7 || pending !== 8'h00) begin
            n_err++; $display("FAIL rmid_grant7 got v=%b idx=%0d pend=%h exp v=1 idx=7 pend=00", out_valid, out_idx, pending);
        end
        step(); step();
        n_cmp++; if (out_valid !== 1'b0 || pending !== 8'h00) begin
            n_err++; $display("FAIL rmid_quiet got v=%b pend=%h exp v=0 pend=00", out_valid, pending);
        end
        req_in = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_seq [9];
`ifdef ROUND_ROBIN_EN
        exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        l_ready = 1'b1; l_req = 8'hFF;
        step();
        n_cmp++; if (l_pend !== 8'hFF || l_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_capture got pend=%h v=%b exp pend=FF v=0", l_pend, l_valid);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++; if (l_valid !== 1'b1 || l_idx !== exp_seq[i]) begin
                n_err++; $display("FAIL b2b_grant%0d got v=%b idx=%0d exp v=1 idx=%0d", i, l_valid, l_idx, exp_seq[i]);
            end
        end
        l_req = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_mask();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_collect_8.md
IRQ_COLLECT_8 -- requirements
Module: irq_collect_8

Interface
REQ-001 Parameter: EDGE_MODE, default 1; 1 = capture on rising edge of req_in bit, 0 = capture while req_in bit is high (level).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_in  input  8  raw request lines, bit 7 highest fixed priority.
REQ-005 mask  input  8  1 = channel blocked from grant (still captured into pending).
REQ-006 ovf_clr  input  1  synchronous clear of overflow.
REQ-007 out_ready  input  1  downstream (priority-encode/consume stage) accepts current grant.
REQ-008 out_valid  output  1  out_idx holds a granted request.
REQ-009 out_idx  output  3  granted channel number (bit position, 0..7).
REQ-010 pending  output  8  captured, not-yet-granted requests.
REQ-011 overflow  output  1  sticky: a capture hit an already-pending channel.

Function
REQ-012 req_in SHALL be registered once (req_q); the edge term is req_in & ~req_q (EDGE_MODE=1) or req_in (EDGE_MODE=0).
REQ-013 pending[i] SHALL set on the cycle after capture term i is 1; latency from req_in rising to pending set = 1 clock.
REQ-014 Grant candidate = pending & ~mask; selection SHALL be highest set bit (fixed priority) unless REQ-024 applies.
REQ-015 Output register SHALL load when (!out_valid || out_ready) and the candidate is nonzero: out_valid<=1, out_idx<=selected bit, pending[selected]<=0 in the same edge.
REQ-016 When (!out_valid || out_ready) and the candidate is zero, out_valid SHALL go 0 on that edge.
REQ-017 While out_valid && !out_ready, out_idx and out_valid SHALL hold stable; pending keeps accumulating.
REQ-018 Minimum latency from req_in rising to out_valid = 2 clocks (req_q/pending, then output register); back-to-back grants with out_ready held high SHALL sustain one grant per clock.
REQ-019 Simultaneous clear (grant) and new capture on the same channel: pending SHALL remain 1 (set wins); overflow SHALL NOT set.
REQ-020 Capture on a channel already pending and not being granted that cycle SHALL set overflow; request is merged (no count).
REQ-021 overflow SHALL clear on ovf_clr=1 unless a new overflow event occurs the same cycle (set wins).
REQ-022 Masking a channel after it is loaded into the output register SHALL NOT revoke the grant.

Reset
REQ-023 rst_n low SHALL immediately force req_q=0, pending=0, out_valid=0, out_idx=0, overflow=0, rotation pointer=0; assertion mid-handshake discards the outstanding grant; the first capture after release uses req_q=0, so a line already high at release counts as a rising edge.

Configuration
REQ-024 Macro ROUND_ROBIN_EN: when defined, selection SHALL be round-robin, searching downward from (last granted index - 1) modulo 8, pointer updated on each load; when undefined, fixed priority per REQ-014 and no pointer register exists.

Verification
REQ-025 Reset, then req_in=8'h00->8'h21 at cycle 0, out_ready=1 -> out_valid at cycle 2 with out_idx=5, cycle 3 out_idx=0, cycle 4 out_valid=0, pending=8'h00.
REQ-026 out_ready=0, pulse bits 2 then 6 -> out_idx=2 held stable; pending=8'h40; raise out_ready -> next grant idx 6.
REQ-027 mask=8'h80, req_in bits 7 and 1 rise -> grant idx 1 only, pending=8'h80; mask=0 -> grant idx 7.
REQ-028 Bit 3 pending (out_ready=0), second rising edge on bit 3 -> overflow=1; ovf_clr pulse -> overflow=0; grant-and-recapture in same cycle -> pending[3]=1, overflow stays 0.
REQ-029 rst_n low for 1 cycle while out_valid=1 and pending=8'hFF -> all outputs 0 asynchronously; no grant reissued after release unless req_in edges recur.
REQ-030 ROUND_ROBIN_EN defined, req_in=8'hFF level high (EDGE_MODE=0), out_ready=1 -> grant sequence 7,6,5,4,3,2,1,0,7; undefined -> 7 repeated.
